// File: rtl/conv_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_enc_pkg
// Brief    : Generators, rate codes and puncture periods for the K=7 encoder.
// Revision : 1.0
// ============================================================================
package conv_enc_pkg;

  localparam logic [6:0] G0 = 7'o133;
  localparam logic [6:0] G1 = 7'o171;

  localparam logic [1:0] RATE_1_2  = 2'b00;
  localparam logic [1:0] RATE_2_3  = 2'b01;
  localparam logic [1:0] RATE_3_4  = 2'b10;
  localparam logic [1:0] RATE_RSVD = 2'b11;

  localparam logic [1:0] PERIOD_1_2 = 2'd1;
  localparam logic [1:0] PERIOD_2_3 = 2'd2;
  localparam logic [1:0] PERIOD_3_4 = 2'd3;

  typedef struct packed {
    logic keep_a;
    logic keep_b;
  } keep_mask_t;

  // Window ordering is {x, s0, s1, s2, s3, s4, s5}, so the octal masks map directly.
  function automatic logic conv_parity(input logic [6:0] gen, input logic [6:0] win);
    return ^(gen & win);
  endfunction

  function automatic logic [1:0] rate_period(input logic [1:0] rate);
    case (rate)
      RATE_2_3: return PERIOD_2_3;
      RATE_3_4: return PERIOD_3_4;
      default:  return PERIOD_1_2;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_puncture.sv
`default_nettype none
// ============================================================================
// Module   : conv_puncture
// Brief    : Rate latch, puncture counter and output packing (CONV_PUNCTURE_EN).
// Revision : 1.0
// ============================================================================
`ifdef CONV_PUNCTURE_EN
module conv_puncture
  import conv_enc_pkg::*;
(
  input  logic       clk_Modulation,
  input  logic       reset,
  input  logic [1:0] coding_rate,
  input  logic       in_valid,
  input  logic       burst_start,
  input  logic       bit_a,
  input  logic       bit_b,
  output logic [1:0] punct_bits,
  output logic [1:0] punct_num,
  output logic       punct_rate_err
);

  logic [1:0] r_rate;
  logic [1:0] r_cnt;
  logic [1:0] w_rate;
  logic [1:0] w_cnt;
  logic [1:0] w_cnt_next;
  keep_mask_t w_keep;

  // The burst-start cycle already uses the freshly latched rate and count zero.
  always_comb begin
    w_rate = r_rate;
    w_cnt  = r_cnt;
    if (burst_start) begin
      w_rate = (coding_rate == RATE_RSVD) ? RATE_1_2 : coding_rate;
      w_cnt  = 2'd0;
    end
    w_cnt_next = ((w_cnt + 2'd1) == rate_period(w_rate)) ? 2'd0 : (w_cnt + 2'd1);
  end

  always_comb begin
    w_keep = '{keep_a: 1'b1, keep_b: 1'b1};
    case (w_rate)
      RATE_2_3: w_keep = '{keep_a: 1'b1, keep_b: (w_cnt == 2'd0)};
      RATE_3_4: w_keep = '{keep_a: (w_cnt != 2'd2), keep_b: (w_cnt != 2'd1)};
      default:  w_keep = '{keep_a: 1'b1, keep_b: 1'b1};
    endcase
  end

  always_comb begin
    punct_bits = {bit_b, bit_a};
    punct_num  = 2'd2;
    if (w_keep.keep_a && !w_keep.keep_b) begin
      punct_bits = {1'b0, bit_a};
      punct_num  = 2'd1;
    end else if (!w_keep.keep_a && w_keep.keep_b) begin
      punct_bits = {1'b0, bit_b};
      punct_num  = 2'd1;
    end
    punct_rate_err = burst_start && (coding_rate == RATE_RSVD);
  end

  always_ff @(posedge clk_Modulation) begin
    if (reset) begin
      r_rate <= RATE_1_2;
      r_cnt  <= 2'd0;
    end else if (in_valid) begin
      r_rate <= w_rate;
      r_cnt  <= w_cnt_next;
    end else begin
      r_cnt  <= 2'd0;
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/conv_encoder_lc.sv
`default_nettype none
// ============================================================================
// Module   : conv_encoder_lc
// Brief    : 802.11a K=7 convolutional encoder; puncturing under CONV_PUNCTURE_EN.
// Revision : 1.0
// ============================================================================
module conv_encoder_lc
  import conv_enc_pkg::*;
(
  input  logic       clk_Modulation,
  input  logic       reset,
  input  logic [1:0] coding_rate,
  input  logic       scramble_bit_valid,
  input  logic       scramble_bit,
  output logic       enc_valid,
  output logic [1:0] enc_bits,
  output logic [1:0] enc_num,
  output logic       rate_err
);

  logic [5:0] r_s;
  logic       r_burst;
  logic [6:0] w_win;
  logic       w_a;
  logic       w_b;
  logic [1:0] w_bits;
  logic [1:0] w_num;
  logic       w_rate_err;

  assign w_win = {scramble_bit, r_s[0], r_s[1], r_s[2], r_s[3], r_s[4], r_s[5]};
  assign w_a   = conv_parity(G0, w_win);
  assign w_b   = conv_parity(G1, w_win);

`ifdef CONV_PUNCTURE_EN
  logic w_burst_start;
  assign w_burst_start = scramble_bit_valid && !r_burst;

  conv_puncture u_puncture (
    .clk_Modulation (clk_Modulation),
    .reset          (reset),
    .coding_rate    (coding_rate),
    .in_valid       (scramble_bit_valid),
    .burst_start    (w_burst_start),
    .bit_a          (w_a),
    .bit_b          (w_b),
    .punct_bits     (w_bits),
    .punct_num      (w_num),
    .punct_rate_err (w_rate_err)
  );
`else
  logic w_unused_rate;
  assign w_unused_rate = ^{coding_rate, r_burst};
  assign w_bits        = {w_b, w_a};
  assign w_num         = 2'd2;
  assign w_rate_err    = 1'b0;
`endif

  // Any idle cycle clears the shift register, so every burst starts from s=0.
  always_ff @(posedge clk_Modulation) begin
    if (reset) begin
      r_s       <= 6'd0;
      r_burst   <= 1'b0;
      enc_valid <= 1'b0;
      enc_bits  <= 2'd0;
      enc_num   <= 2'd0;
      rate_err  <= 1'b0;
    end else begin
      r_burst   <= scramble_bit_valid;
      r_s       <= scramble_bit_valid ? {r_s[4:0], scramble_bit} : 6'd0;
      enc_valid <= scramble_bit_valid;
      enc_bits  <= scramble_bit_valid ? w_bits : 2'd0;
      enc_num   <= scramble_bit_valid ? w_num : 2'd0;
      rate_err  <= scramble_bit_valid && w_rate_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder_lc.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_encoder_lc
// Brief    : Self-checking bench for conv_encoder_lc against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_conv_encoder_lc;

  logic       clk_Modulation = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] coding_rate = 2'b00;
  logic       scramble_bit_valid = 1'b0;
  logic       scramble_bit = 1'b0;
  logic       enc_valid;
  logic [1:0] enc_bits;
  logic [1:0] enc_num;
  logic       rate_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_Modulation = ~clk_Modulation;

  conv_encoder_lc dut (
    .clk_Modulation     (clk_Modulation),
    .reset              (reset),
    .coding_rate        (coding_rate),
    .scramble_bit_valid (scramble_bit_valid),
    .scramble_bit       (scramble_bit),
    .enc_valid          (enc_valid),
    .enc_bits           (enc_bits),
    .enc_num            (enc_num),
    .rate_err           (rate_err)
  );

  localparam logic [6:0] M_G0 = 7'o133;
  localparam logic [6:0] M_G1 = 7'o171;

  bit         m_in_burst = 1'b0;
  int         m_pos = 0;
  int         m_rate = 0;
  bit         m_hist[$];
  logic [13:0] ab_seq;
  int         num_sum;

  // Coded bit = XOR over generator taps of the current bit and the bits k cycles back.
  function automatic bit gen_out(logic [6:0] g, bit x);
    bit r;
    r = x & g[6];
    for (int k = 1; k <= 6; k++)
      if (k <= m_hist.size()) r ^= g[6-k] & m_hist[k-1];
    return r;
  endfunction

  task automatic check_vec(string tag, logic [5:0] e);
    logic [5:0] obs;
    obs = {enc_valid, enc_bits, enc_num, rate_err};
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed {v,bits,num,err}=%b expected %b", tag, obs, e);
    end
  endtask

  task automatic check_int(string tag, int obs, int e);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
    end
  endtask

  task automatic step(string tag, bit v, bit x, logic [1:0] rate);
    logic [5:0] e;
    bit a, b, err;
    int ph;
    @(negedge clk_Modulation);
    reset = 1'b0;
    scramble_bit_valid = v;
    scramble_bit = x;
    coding_rate = rate;
    e = 6'd0;
    if (v) begin
      err = 1'b0;
      if (!m_in_burst) begin
        m_in_burst = 1'b1;
        m_pos = 0;
        m_hist.delete();
`ifdef CONV_PUNCTURE_EN
        if (rate == 2'b11) begin
          m_rate = 0;
          err = 1'b1;
        end else begin
          m_rate = int'(rate);
        end
`else
        m_rate = 0;
`endif
      end
      a = gen_out(M_G0, x);
      b = gen_out(M_G1, x);
      // Puncture periods 1, 2, 3; phase 0 keeps both, 1 keeps A, 2 keeps B.
      ph = m_pos % (m_rate + 1);
      if (ph == 0)      e = {1'b1, b, a, 2'd2, err};
      else if (ph == 1) e = {1'b1, 1'b0, a, 2'd1, err};
      else              e = {1'b1, 1'b0, b, 2'd1, err};
      m_pos++;
      m_hist.push_front(x);
      if (m_hist.size() > 6) void'(m_hist.pop_back());
    end else begin
      m_in_burst = 1'b0;
    end
    @(posedge clk_Modulation);
    #1;
    check_vec(tag, e);
    if (enc_valid) begin
      ab_seq = {ab_seq[11:0], enc_bits[0], enc_bits[1]};
      num_sum += int'(enc_num);
    end
  endtask

  task automatic do_reset(bit v);
    @(negedge clk_Modulation);
    reset = 1'b1;
    scramble_bit_valid = v;
    scramble_bit = 1'b1;
    @(posedge clk_Modulation);
    #1;
    check_vec("reset", 6'd0);
    m_in_burst = 1'b0;
    m_hist.delete();
  endtask

  task automatic run_bits(string tag, logic [1:0] rate, int n, logic [15:0] bits);
    ab_seq = '0;
    num_sum = 0;
    for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, bits[i], rate);
  endtask

  initial begin
    int blen, gap;
    logic [15:0] rb;

    do_reset(1'b0);
    do_reset(1'b0);

    run_bits("impulse_r12", 2'b00, 7, 16'b1000000);
    check_int("impulse_r12_ab", int'(ab_seq), int'(14'b11011111001011));
    step("idle", 1'b0, 1'b0, 2'b00);

    run_bits("ones_r12", 2'b00, 7, 16'b1111111);
    check_int("ones_r12_ab", int'(ab_seq), int'(14'b11100110100011));
    check_int("ones_r12_num", num_sum, 14);
    step("idle", 1'b0, 1'b0, 2'b00);

    run_bits("impulse_r34", 2'b10, 3, 16'b100);
    step("idle", 1'b0, 1'b0, 2'b00);

    rb = 16'($urandom);
    run_bits("six_r34", 2'b10, 6, rb);
`ifdef CONV_PUNCTURE_EN
    check_int("six_r34_total", num_sum, 8);
`else
    check_int("six_r34_total", num_sum, 12);
`endif
    step("idle", 1'b0, 1'b0, 2'b00);

    run_bits("four_r23", 2'b01, 4, 16'b1100);
`ifdef CONV_PUNCTURE_EN
    check_int("four_r23_total", num_sum, 6);
`else
    check_int("four_r23_total", num_sum, 8);
`endif
    step("idle", 1'b0, 1'b0, 2'b00);

    step("rate_change", 1'b1, 1'b1, 2'b10);
    step("rate_change", 1'b1, 1'b0, 2'b00);
    step("rate_change", 1'b1, 1'b1, 2'b01);
    step("rate_change", 1'b1, 1'b1, 2'b11);
    step("rate_change", 1'b1, 1'b0, 2'b00);
    step("idle", 1'b0, 1'b0, 2'b00);

    run_bits("split_first", 2'b10, 3, 16'b101);
    step("split_gap", 1'b0, 1'b0, 2'b10);
    run_bits("split_second", 2'b00, 7, 16'b1000000);
    check_int("split_second_ab", int'(ab_seq), int'(14'b11011111001011));
    step("idle", 1'b0, 1'b0, 2'b00);

    run_bits("rsvd_rate", 2'b11, 5, 16'b10110);
    check_int("rsvd_rate_num", num_sum, 10);
    step("idle", 1'b0, 1'b0, 2'b00);

    run_bits("pre_reset", 2'b10, 4, 16'b1101);
    do_reset(1'b1);
    run_bits("post_reset", 2'b00, 7, 16'b1000000);
    check_int("post_reset_ab", int'(ab_seq), int'(14'b11011111001011));
    step("idle", 1'b0, 1'b0, 2'b00);

    for (int n = 0; n < 40; n++) begin
      blen = int'($urandom_range(1, 12));
      for (int i = 0; i < blen; i++)
        step("random", 1'b1, 1'($urandom), 2'($urandom));
      gap = int'($urandom_range(1, 3));
      for (int i = 0; i < gap; i++)
        step("random_gap", 1'b0, 1'($urandom), 2'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
